// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
//   Shared definitions for the common data bus (CDB) arbiter slice:
//   - NUM_CDB_SRC / CDB_QDEPTH : default source count and per-source FIFO depth
//   - cdb_src_e                : names of the CDB producers (index on cdb_src)
//   - ex_wr_packet_t           : execute write-back packet broadcast on the CDB
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

  localparam int NUM_CDB_SRC = 4;
  localparam int CDB_QDEPTH  = 2;
  localparam int ROB_TAG_W   = 6;

  typedef enum logic [1:0] {
    CDB_SRC_ALU0  = 2'd0,
    CDB_SRC_ALU1  = 2'd1,
    CDB_SRC_STORE = 2'd2,
    CDB_SRC_LOAD  = 2'd3
  } cdb_src_e;

  typedef struct packed {
    logic                 valid;
    logic [31:0]          value;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [31:0]          npc;
    logic [31:0]          inst;
  } ex_wr_packet_t;

endpackage

// File: rtl/cdb_arbiter_src_fifo.sv
// -----------------------------------------------------------------------------
// cdb_src_fifo
//   Single-source FIFO of ex_wr_packet_t feeding one CDB arbiter input.
//   Ports:
//     clock, reset   : clock, synchronous active-high reset
//     squash         : mispredict flush, empties the FIFO on the clock edge
//     push/push_data : enqueue request and packet (ignored when full)
//     pop            : dequeue request (ignored when empty)
//     head           : packet at the head of the FIFO
//     full, empty    : occupancy flags (full is count == QDEPTH)
// -----------------------------------------------------------------------------
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int QDEPTH = CDB_QDEPTH
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          squash,
  input  logic          push,
  input  ex_wr_packet_t push_data,
  input  logic          pop,
  output ex_wr_packet_t head,
  output logic          full,
  output logic          empty
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;

  ex_wr_packet_t   mem [QDEPTH];
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   tail_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(QDEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[head_ptr];

  // Storage has no reset: contents are only observable once count says so.
  always_ff @(posedge clock) begin
    if (do_push && !reset && !squash) begin
      mem[tail_ptr] <= push_data;
    end
  end

  // QDEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + 1'b1;
      if (do_pop)  head_ptr <= head_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Shares the common data bus among NUM_SRC result producers. Each producer
//   has its own FIFO; a round-robin arbiter drains one packet per cycle.
//   Ports:
//     clock, reset  : clock, synchronous active-high reset
//     squash        : mispredict flush, discards every queued result
//     fu_packet_in  : per-source result packets; entry i accepted when
//                     valid && !fu_stall[i] && !squash
//     fu_stall      : per-source full flag (combinational, count == QDEPTH,
//                     does not credit a same-cycle pop)
//     cdb_out       : broadcast packet
//     cdb_src       : index of the source driving cdb_out
//
//   Handshake: a producer presents a packet with valid=1 and holds it
//   unchanged until a cycle where fu_stall[i]=0; the packet is taken on that
//   clock edge (unless squash is high, in which case it is dropped).
//
//   Build option CDB_ARB_BYPASS_EN: when defined, cdb_out/cdb_src are
//   combinational and an empty source with an acceptable incoming packet can
//   win arbitration and go straight to the bus without being enqueued. When
//   undefined, the bus output is registered (1-cycle minimum latency).
// -----------------------------------------------------------------------------
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = NUM_CDB_SRC,
  parameter int QDEPTH  = CDB_QDEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  ex_wr_packet_t              fu_packet_in [NUM_SRC],
  output logic [NUM_SRC-1:0]         fu_stall,
  output ex_wr_packet_t              cdb_out,
  output logic [$clog2(NUM_SRC)-1:0] cdb_src
);

  localparam int SW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] push_ok;
  logic [NUM_SRC-1:0] push_en;
  logic [NUM_SRC-1:0] pop_en;
  logic [NUM_SRC-1:0] cand;
  ex_wr_packet_t      head_pkt [NUM_SRC];
  logic               found;
  logic [SW-1:0]      winner;
  logic [SW-1:0]      rr_ptr;

  assign fu_stall = full;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
    cdb_src_fifo #(.QDEPTH(QDEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .squash    (squash),
      .push      (push_en[g]),
      .push_data (fu_packet_in[g]),
      .pop       (pop_en[g]),
      .head      (head_pkt[g]),
      .full      (full[g]),
      .empty     (empty[g])
    );
  end

  // Candidate set. In the bypass build an empty source with an acceptable
  // incoming packet also competes this cycle.
  always_comb begin
    push_ok = '0;
    cand    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      push_ok[i] = fu_packet_in[i].valid && !full[i] && !squash;
`ifdef CDB_ARB_BYPASS_EN
      cand[i] = !empty[i] || push_ok[i];
`else
      cand[i] = !empty[i];
`endif
    end
  end

  // Round-robin pick: first candidate scanning rr_ptr, rr_ptr+1, ...
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_SRC;
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = SW'(idx);
      end
    end
  end

  always_comb begin
    pop_en  = '0;
    push_en = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pop_en[i] = found && (winner == SW'(i)) && !empty[i] && !squash;
`ifdef CDB_ARB_BYPASS_EN
      // A bypassed packet is consumed by the bus and never enqueued.
      push_en[i] = push_ok[i] && !(found && (winner == SW'(i)) && empty[i]);
`else
      push_en[i] = push_ok[i];
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= SW'((int'(winner) + 1) % NUM_SRC);
    end
  end

`ifdef CDB_ARB_BYPASS_EN
  always_comb begin
    cdb_out = '0;
    cdb_src = winner;
    if (found && !squash && !reset) begin
      cdb_out       = empty[winner] ? fu_packet_in[winner] : head_pkt[winner];
      cdb_out.valid = 1'b1;
    end
  end
`else
  // Non-valid cycles keep the last payload; only valid drops.
  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_out <= '0;
      cdb_src <= '0;
    end else if (found && !squash) begin
      cdb_out       <= head_pkt[winner];
      cdb_out.valid <= 1'b1;
      cdb_src       <= winner;
    end else begin
      cdb_out.valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//   Scoreboard bench for cdb_arbiter (registered-output build). A queue-based
//   reference model predicts every cycle's bus contents and pushes them into
//   exp_q; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NUM = 4;
  localparam int QD  = 2;
  localparam int SW  = 2;
  localparam int W   = 1 + SW + ROB_TAG_W + 96;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          squash = 1'b0;
  ex_wr_packet_t fu_packet_in [NUM];
  logic [NUM-1:0] fu_stall;
  ex_wr_packet_t cdb_out;
  logic [SW-1:0] cdb_src;

  always #5 clock = ~clock;

  cdb_arbiter #(.NUM_SRC(NUM), .QDEPTH(QD)) dut (
    .clock        (clock),
    .reset        (reset),
    .squash       (squash),
    .fu_packet_in (fu_packet_in),
    .fu_stall     (fu_stall),
    .cdb_out      (cdb_out),
    .cdb_src      (cdb_src)
  );

  // ---------------- scoreboard state ----------------
  int             errors = 0;
  int             checks = 0;
  logic [W-1:0]   exp_q[$];
  ex_wr_packet_t  model_q [NUM][$];
  int             rr_model = 0;
  logic           model_known = 1'b0;

  ex_wr_packet_t  drv [NUM];
  logic           drv_reset = 1'b1;
  logic           drv_squash = 1'b0;
  logic [NUM-1:0] accepted;

  function automatic logic [W-1:0] pack_exp(logic v, logic [SW-1:0] s, ex_wr_packet_t p);
    return {v, s, p.rob_tag, p.value, p.npc, p.inst};
  endfunction

  function automatic ex_wr_packet_t mk(int tag, logic [31:0] v);
    ex_wr_packet_t p;
    p.valid   = 1'b1;
    p.rob_tag = ROB_TAG_W'(tag);
    p.value   = v;
    p.npc     = v + 32'd4;
    p.inst    = ~v;
    return p;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin : monitor
    logic [W-1:0] e;
    logic [W-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = pack_exp(cdb_out.valid, cdb_src, cdb_out);
      checks++;
      if (e[W-1] == 1'b0) begin
        if (cdb_out.valid !== 1'b0) begin
          errors++;
          $display("FAIL cdb_idle @%0t: valid=%b src=%0d tag=%0d, required valid=0",
                   $time, cdb_out.valid, cdb_src, cdb_out.rob_tag);
        end
      end else if (a !== e) begin
        errors++;
        $display("FAIL cdb_pkt @%0t: got valid=%b src=%0d tag=%0d value=%h, required valid=1 src=%0d tag=%0d value=%h (full got=%h req=%h)",
                 $time, cdb_out.valid, cdb_src, cdb_out.rob_tag, cdb_out.value,
                 e[W-2 -: SW], e[W-2-SW -: ROB_TAG_W], e[95:64], a, e);
      end
    end
  end

  // ---------------- driver + reference model ----------------
  task automatic step();
    int            w;
    int            s;
    logic          exp_s;
    ex_wr_packet_t p;
    @(negedge clock);
    reset  = drv_reset;
    squash = drv_squash;
    for (int i = 0; i < NUM; i++) fu_packet_in[i] = drv[i];
    #1;
    if (model_known) begin
      for (int i = 0; i < NUM; i++) begin
        exp_s = (model_q[i].size() == QD);
        checks++;
        if (fu_stall[i] !== exp_s) begin
          errors++;
          $display("FAIL fu_stall[%0d] @%0t: got %b, required %b", i, $time, fu_stall[i], exp_s);
        end
      end
    end
    accepted = '0;
    if (drv_reset || drv_squash) begin
      for (int i = 0; i < NUM; i++) model_q[i].delete();
      rr_model = 0;
      exp_q.push_back('0);
      if (drv_reset) model_known = 1'b1;
    end else begin
      for (int i = 0; i < NUM; i++)
        accepted[i] = drv[i].valid && (model_q[i].size() < QD);
      w = -1;
      for (int k = 0; k < NUM; k++) begin
        s = (rr_model + k) % NUM;
        if (w < 0 && model_q[s].size() > 0) w = s;
      end
      if (w >= 0) begin
        p = model_q[w].pop_front();
        exp_q.push_back(pack_exp(1'b1, SW'(w), p));
        rr_model = (w + 1) % NUM;
      end else begin
        exp_q.push_back('0);
      end
      for (int i = 0; i < NUM; i++)
        if (accepted[i]) model_q[i].push_back(drv[i]);
    end
  endtask

  task automatic clear_drv();
    drv_reset  = 1'b0;
    drv_squash = 1'b0;
    for (int i = 0; i < NUM; i++) drv[i] = '0;
  endtask

  task automatic idle(int n);
    clear_drv();
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    clear_drv();
    drv_reset = 1'b1;
    step();
    drv_reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int tag;
    for (int i = 0; i < NUM; i++) fu_packet_in[i] = '0;

    // Reset, then idle.
    clear_drv();
    drv_reset = 1'b1;
    step();
    step();
    idle(5);
    checks++;
    if (cdb_src !== 2'd0 || cdb_out.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: cdb_src=%0d valid=%b, required 0 0", cdb_src, cdb_out.valid);
    end

    // Single push on the store path.
    drv[CDB_SRC_STORE] = mk(5, 32'h1234);
    step();
    idle(3);

    // Two simultaneous bursts from a fresh rr pointer.
    do_reset();
    idle(1);
    for (int i = 0; i < NUM; i++) drv[i] = mk(10 + i, 32'hA000 + i);
    step();
    idle(5);
    for (int i = 0; i < NUM; i++) drv[i] = mk(20 + i, 32'hB000 + i);
    step();
    idle(5);

    // src1 streams while src0 holds one entry; producer holds under stall.
    tag = 1;
    drv[0] = mk(30, 32'hC0DE);
    for (int n = 0; n < 40 && tag <= 8; n++) begin
      drv[1] = mk(tag, 32'h100 + tag);
      step();
      drv[0].valid = 1'b0;
      if (accepted[1]) tag++;
    end
    idle(4);
    checks++;
    if (tag != 9) begin
      errors++;
      $display("FAIL src1_stream: accepted up to tag %0d, required 9", tag);
    end

    // Squash with src3 full and a concurrent push on src0.
    do_reset();
    for (int i = 0; i < NUM; i++) drv[i] = mk(40 + i, 32'hD000 + i);
    step();
    clear_drv();
    drv[3] = mk(50, 32'hD050);
    step();
    clear_drv();
    drv_squash = 1'b1;
    drv[0] = mk(60, 32'hD060);
    step();
    idle(6);

    // Reset mid-burst, then a post-reset push on src3.
    for (int i = 0; i < NUM; i++) drv[i] = mk(a_tag(i), 32'hE000 + i);
    step();
    idle(1);
    do_reset();
    idle(2);
    drv[3] = mk(15, 32'hE0F0);
    step();
    idle(3);

    // Randomized traffic with occasional squash and reset.
    clear_drv();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NUM; i++)
        if (!drv[i].valid && $urandom_range(0, 99) < 60)
          drv[i] = mk($urandom_range(0, 63), $urandom);
      drv_squash = ($urandom_range(0, 59) == 0);
      drv_reset  = ($urandom_range(0, 149) == 0);
      step();
      for (int i = 0; i < NUM; i++)
        if (accepted[i] || drv_squash || drv_reset) drv[i].valid = 1'b0;
    end

    idle(12);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected items left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic int a_tag(int i);
    return 70 + i;
  endfunction

endmodule
